// File: rtl/csa_job_scheduler_if.sv
// csa_job_scheduler_if: merged engine result stream (valid/ready plus the
// index of the engine that produced each record).
interface csa_job_scheduler_if #(
    parameter int DATA_W = 224,
    parameter int ID_W   = 2
);
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;
    logic [ID_W-1:0]   res_engine;

    modport master (
        output res_valid,
        output res_data,
        output res_engine,
        input  res_ready
    );

    modport slave (
        input  res_valid,
        input  res_data,
        input  res_engine,
        output res_ready
    );
endinterface

// File: rtl/csa_job_scheduler.sv
// csa_job_scheduler: splits one CSA search job into chunks for an engine
// array and merges the engine result records into one valid/ready stream.
module csa_job_scheduler #(
    parameter int AXI_DATA_WIDTH           = 32,
    parameter int NUM_ENGINES              = 4,
    parameter int ENG_ID_WIDTH             = 2,
    parameter int CSA_IN_PARAMETER_LENGTH  = AXI_DATA_WIDTH * 5,
    parameter int CSA_OUT_PARAMETER_LENGTH = AXI_DATA_WIDTH * 7
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          abort,
    input  logic [AXI_DATA_WIDTH-1:0]     cfg_block,
    input  logic [2*AXI_DATA_WIDTH-1:0]   cfg_in,
    input  logic [AXI_DATA_WIDTH-1:0]     cfg_times_start,
    input  logic [AXI_DATA_WIDTH-1:0]     cfg_total,
    input  logic [AXI_DATA_WIDTH-1:0]     cfg_chunk,
    output logic                          busy,
    output logic                          done,
    output logic [AXI_DATA_WIDTH-1:0]     chunks_issued,
    output logic [AXI_DATA_WIDTH-1:0]     results_seen,
    input  logic [NUM_ENGINES-1:0]        eng_in_full,
    output logic [NUM_ENGINES-1:0]        eng_in_wen,
    output logic [CSA_IN_PARAMETER_LENGTH-1:0] eng_in_data,
    input  logic [NUM_ENGINES-1:0]        eng_out_ready,
    output logic [NUM_ENGINES-1:0]        eng_out_ren,
    input  logic [NUM_ENGINES*CSA_OUT_PARAMETER_LENGTH-1:0] eng_out_data,
    csa_job_scheduler_if.master           res
);
    localparam int W   = AXI_DATA_WIDTH;
    localparam int N   = NUM_ENGINES;
    localparam int IDW = ENG_ID_WIDTH;
    localparam int OW  = CSA_OUT_PARAMETER_LENGTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]   blk_q, chunk_q, remaining, next_start;
    logic [2*W-1:0] seed_q;
    logic [W-1:0]   times_now, rem_after;
    logic [IDW-1:0] rr_in, rr_out, in_k, out_k, rd_k;
    logic           in_found, out_found;
    logic           go, do_write, do_read;
    logic [N-1:0]   in_oh, out_oh;
    logic [OW-1:0]  rd_slice;

    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] k);
        if (int'(k) >= N - 1) return '0;
        return k + 1'b1;
    endfunction

    // First available index at or after base, wrapping; MSB = found.
    function automatic logic [IDW:0] rr_pick(
        input logic [N-1:0]   avail,
        input logic [IDW-1:0] base
    );
        logic [IDW:0] r;
        r = '0;
        for (int j = 0; j < N; j++)
            if (!r[IDW] && avail[j] && IDW'(j) >= base)
                r = {1'b1, IDW'(j)};
        for (int j = 0; j < N; j++)
            if (!r[IDW] && avail[j])
                r = {1'b1, IDW'(j)};
        return r;
    endfunction

    // Full flag lags one write, so the engine written last cycle is skipped.
    assign {in_found, in_k}   = rr_pick(~eng_in_full & ~eng_in_wen, rr_in);
    assign {out_found, out_k} = rr_pick(eng_out_ready, rr_out);

    assign go        = start && !abort;
    assign times_now = (chunk_q < remaining) ? chunk_q : remaining;
    assign rem_after = remaining - times_now;
    assign do_write  = (state_q == S_DISPATCH) && !abort &&
                       (remaining != '0) && in_found;
    assign do_read   = !(|eng_out_ren) && out_found &&
                       (!res.res_valid || res.res_ready);

    always_comb begin
        in_oh  = '0;
        out_oh = '0;
        for (int j = 0; j < N; j++) begin
            in_oh[j]  = (in_k == IDW'(j));
            out_oh[j] = (out_k == IDW'(j));
        end
    end

    always_comb begin
        rd_slice = '0;
        for (int j = 0; j < N; j++)
            if (rd_k == IDW'(j))
                rd_slice = eng_out_data[j*OW +: OW];
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go)
                    state_d = (cfg_total == '0) ? S_DONE : S_DISPATCH;
            end
            S_DISPATCH: begin
                busy = 1'b1;
                if (abort)
                    state_d = S_IDLE;
                else if (do_write && rem_after == '0)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (abort)
                    state_d = S_IDLE;
                else if (results_seen >= chunks_issued)
                    state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blk_q         <= '0;
            seed_q        <= '0;
            chunk_q       <= '0;
            remaining     <= '0;
            next_start    <= '0;
            rr_in         <= '0;
            chunks_issued <= '0;
            results_seen  <= '0;
            eng_in_wen    <= '0;
            eng_in_data   <= '0;
            done          <= 1'b0;
        end else begin
            eng_in_wen <= do_write ? in_oh : '0;
            done       <= (state_q == S_DONE) && !abort;
            if (state_q == S_IDLE && go) begin
                blk_q         <= cfg_block;
                seed_q        <= cfg_in;
                chunk_q       <= (cfg_chunk == '0) ? W'(1) : cfg_chunk;
                remaining     <= cfg_total;
                next_start    <= cfg_times_start;
                chunks_issued <= '0;
                results_seen  <= '0;
            end
            if (do_write) begin
                eng_in_data   <= {next_start, times_now, seed_q, blk_q};
                remaining     <= rem_after;
                next_start    <= next_start + times_now;
                chunks_issued <= chunks_issued + 1'b1;
                rr_in         <= rr_next(in_k);
            end
            if (busy && res.res_valid && res.res_ready && results_seen != '1)
                results_seen <= results_seen + 1'b1;
        end
    end

    // Output FIFOs present the head record while ren is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            eng_out_ren    <= '0;
            rr_out         <= '0;
            rd_k           <= '0;
            res.res_valid  <= 1'b0;
            res.res_data   <= '0;
            res.res_engine <= '0;
        end else begin
            eng_out_ren <= do_read ? out_oh : '0;
            if (do_read) begin
                rd_k   <= out_k;
                rr_out <= rr_next(out_k);
            end
            if (|eng_out_ren) begin
                res.res_valid  <= 1'b1;
                res.res_data   <= rd_slice;
                res.res_engine <= rd_k;
            end else if (res.res_valid && res.res_ready) begin
                res.res_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_csa_job_scheduler.sv
// tb_csa_job_scheduler: directed checks of chunk dispatch, result merge,
// abort and boundary cases for csa_job_scheduler.
module tb_csa_job_scheduler;
    localparam int N  = 4;
    localparam int OW = 224;

    logic            clk = 1'b0;
    logic            rst, start, abort;
    logic [31:0]     cfg_block, cfg_times_start, cfg_total, cfg_chunk;
    logic [63:0]     cfg_in;
    logic            busy, done;
    logic [31:0]     chunks_issued, results_seen;
    logic [N-1:0]    eng_in_full, eng_in_wen, eng_out_ready, eng_out_ren;
    logic [159:0]    eng_in_data;
    logic [N*OW-1:0] eng_out_data;

    csa_job_scheduler_if #(.DATA_W(OW), .ID_W(2)) res_if ();

    csa_job_scheduler #(
        .AXI_DATA_WIDTH(32),
        .NUM_ENGINES(N),
        .ENG_ID_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .abort(abort),
        .cfg_block(cfg_block),
        .cfg_in(cfg_in),
        .cfg_times_start(cfg_times_start),
        .cfg_total(cfg_total),
        .cfg_chunk(cfg_chunk),
        .busy(busy),
        .done(done),
        .chunks_issued(chunks_issued),
        .results_seen(results_seen),
        .eng_in_full(eng_in_full),
        .eng_in_wen(eng_in_wen),
        .eng_in_data(eng_in_data),
        .eng_out_ready(eng_out_ready),
        .eng_out_ren(eng_out_ren),
        .eng_out_data(eng_out_data),
        .res(res_if.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pend[N];
    int done_cnt;
    int wr_eng[$];
    int wr_times[$];
    logic [31:0] wr_start[$];
    logic [31:0] wr_block[$];
    logic [63:0] wr_in[$];
    int ren_eng[$];
    int hs_eng[$];
    logic [OW-1:0] hs_data[$];

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [OW-1:0] pat(input int k);
        logic [OW-1:0] p;
        p = '0;
        for (int w = 0; w < 7; w++)
            p[w*32 +: 32] = 32'hA500_0000 | (k << 8) | w;
        return p;
    endfunction

    task automatic upd_ready();
        for (int k = 0; k < N; k++) eng_out_ready[k] = (pend[k] > 0);
    endtask

    task automatic load(input int a, input int b, input int c, input int d);
        pend[0] = a; pend[1] = b; pend[2] = c; pend[3] = d;
        upd_ready();
    endtask

    // One cycle: log the handshake due at the coming edge, then observe at negedge.
    task automatic tick();
        if (res_if.res_valid && res_if.res_ready) begin
            hs_eng.push_back(int'(res_if.res_engine));
            hs_data.push_back(res_if.res_data);
        end
        @(negedge clk);
        if (|eng_in_wen) begin
            check("wen_onehot", $countones(eng_in_wen), 1);
            for (int k = 0; k < N; k++)
                if (eng_in_wen[k]) wr_eng.push_back(k);
            wr_block.push_back(eng_in_data[31:0]);
            wr_in.push_back(eng_in_data[95:32]);
            wr_times.push_back(int'(eng_in_data[127:96]));
            wr_start.push_back(eng_in_data[159:128]);
        end
        if (|eng_out_ren) begin
            check("ren_onehot", $countones(eng_out_ren), 1);
            for (int k = 0; k < N; k++)
                if (eng_out_ren[k]) begin
                    ren_eng.push_back(k);
                    if (pend[k] > 0) pend[k]--;
                end
        end
        upd_ready();
        if (done) done_cnt++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_done(input int bound);
        int d0;
        int b;
        d0 = done_cnt;
        b = 0;
        while (done_cnt == d0 && b < bound) begin
            tick();
            b++;
        end
    endtask

    task automatic clr();
        wr_eng.delete(); wr_times.delete(); wr_start.delete();
        wr_block.delete(); wr_in.delete();
        ren_eng.delete(); hs_eng.delete(); hs_data.delete();
        done_cnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_block = '0; cfg_in = '0; cfg_times_start = '0;
        cfg_total = '0; cfg_chunk = '0;
        eng_in_full = '0;
        res_if.res_ready = 1'b0;
        load(0, 0, 0, 0);
        run(2);
        rst = 1'b0;
        clr();
    endtask

    task automatic start_job(input logic [31:0] blk, input logic [63:0] seed,
                             input logic [31:0] ts, input logic [31:0] tot,
                             input logic [31:0] ch);
        cfg_block = blk; cfg_in = seed; cfg_times_start = ts;
        cfg_total = tot; cfg_chunk = ch;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int ea[4];
        int chg;
        for (int k = 0; k < N; k++) eng_out_data[k*OW +: OW] = pat(k);
        do_reset();

        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_chunks", chunks_issued, 0);
        check("rst_results", results_seen, 0);
        check("rst_wen", eng_in_wen, 0);
        check("rst_ren", eng_out_ren, 0);
        check("rst_valid", res_if.res_valid, 0);
        check("rst_engine", res_if.res_engine, 0);
        check("rst_data", eng_in_data, 0);

        // Basic job: 10 times in chunks of 4 starting at 100.
        clr();
        start_job(32'd7, 64'h1122_3344_5566_7788, 32'd100, 32'd10, 32'd4);
        check("a_busy", busy, 1);
        run(8);
        check("a_nwr", wr_eng.size(), 3);
        ea = '{0, 1, 2, 0};
        if (wr_eng.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("a_eng", wr_eng[i], ea[i]);
                check("a_times", wr_times[i], (i == 2) ? 2 : 4);
                check("a_start", wr_start[i], 100 + 4 * i);
                check("a_block", wr_block[i], 32'd7);
                check("a_seed", wr_in[i], 64'h1122_3344_5566_7788);
            end
        end
        check("a_chunks", chunks_issued, 3);
        check("a_drain_busy", busy, 1);
        check("a_no_early_done", done_cnt, 0);
        load(1, 1, 1, 0);
        res_if.res_ready = 1'b1;
        wait_done(40);
        run(3);
        check("a_done", done_cnt, 1);
        check("a_results", results_seen, 3);
        check("a_busy_end", busy, 0);
        check("a_nhs", hs_eng.size(), 3);
        if (hs_eng.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check("a_hs_eng", hs_eng[i], ea[i]);
                check("a_hs_data", hs_data[i], pat(ea[i]));
            end
        end

        // times_start wraps past 2^32.
        clr();
        res_if.res_ready = 1'b0;
        start_job(32'd5, 64'hDEAD_BEEF_0000_0001, 32'hFFFF_FFFE, 32'd6, 32'd4);
        run(6);
        check("b_nwr", wr_eng.size(), 2);
        if (wr_eng.size() == 2) begin
            check("b_eng0", wr_eng[0], 3);
            check("b_eng1", wr_eng[1], 0);
            check("b_start0", wr_start[0], 32'hFFFF_FFFE);
            check("b_start1", wr_start[1], 32'h0000_0002);
            check("b_times0", wr_times[0], 4);
            check("b_times1", wr_times[1], 2);
        end
        load(1, 0, 0, 1);
        res_if.res_ready = 1'b1;
        wait_done(40);
        check("b_done", done_cnt, 1);
        check("b_results", results_seen, 2);
        check("b_nhs", hs_eng.size(), 2);
        if (hs_eng.size() == 2) begin
            check("b_hs0", hs_eng[0], 3);
            check("b_hs1", hs_eng[1], 0);
        end

        // Engines 0,1 full: alternate 2,3; then abort mid-dispatch.
        clr();
        res_if.res_ready = 1'b0;
        eng_in_full = 4'b0011;
        start_job(32'd1, 64'd0, 32'd0, 32'd100, 32'd2);
        for (int b = 0; b < 20 && wr_eng.size() < 4; b++) tick();
        check("c_nwr", wr_eng.size(), 4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("c_abort_busy", busy, 0);
        run(10);
        check("c_nwr_after", wr_eng.size(), 4);
        check("c_chunks", chunks_issued, 4);
        check("c_no_done", done_cnt, 0);
        if (wr_eng.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("c_eng", wr_eng[i], (i % 2 == 0) ? 2 : 3);
                check("c_start", wr_start[i], 2 * i);
            end
        end
        for (int i = 1; i < wr_eng.size(); i++)
            check("c_alt", wr_eng[i] != wr_eng[i-1], 1);
        eng_in_full = '0;

        // Result backpressure in IDLE, then round-robin drain.
        do_reset();
        load(1, 1, 1, 1);
        chg = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (res_if.res_valid && res_if.res_data !== pat(0)) chg++;
        end
        check("d_nren", ren_eng.size(), 1);
        check("d_valid", res_if.res_valid, 1);
        check("d_engine", res_if.res_engine, 0);
        check("d_data", res_if.res_data, pat(0));
        check("d_stable", chg, 0);
        res_if.res_ready = 1'b1;
        run(12);
        check("d_nhs", hs_eng.size(), 4);
        if (hs_eng.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check("d_hs_eng", hs_eng[i], i);
                check("d_hs_data", hs_data[i], pat(i));
            end
        end
        check("d_idle_results", results_seen, 0);

        // Zero-length job: done two cycles after start, no writes.
        clr();
        start_job(32'd0, 64'd0, 32'd0, 32'd0, 32'd4);
        check("e_done_early", done, 0);
        check("e_busy", busy, 0);
        tick();
        check("e_done", done, 1);
        run(3);
        check("e_nwr", wr_eng.size(), 0);
        check("e_done_cnt", done_cnt, 1);

        // chunk 0 acts as 1; start while busy ignored; abort from DRAIN.
        do_reset();
        start_job(32'd9, 64'd5, 32'd50, 32'd2, 32'd0);
        run(5);
        check("f_nwr", wr_eng.size(), 2);
        if (wr_eng.size() == 2) begin
            check("f_times0", wr_times[0], 1);
            check("f_times1", wr_times[1], 1);
            check("f_start1", wr_start[1], 32'd51);
            check("f_eng1", wr_eng[1], 1);
        end
        start_job(32'd3, 64'd0, 32'd0, 32'd8, 32'd1);
        run(3);
        check("f_ignored_nwr", wr_eng.size(), 2);
        check("f_ignored_chunks", chunks_issued, 2);
        check("f_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        run(2);
        check("f_abort_busy", busy, 0);
        check("f_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
